// File: rtl/mealy_seq_detector_pkg.sv
// Shared constants and helpers for the Mealy sequence detector.
// Overlap mode encodings, state width and symbol extraction.
package mealy_pkg;

  localparam logic MODE_NONOVL = 1'b0;
  localparam logic MODE_OVL    = 1'b1;

  localparam int SYM_MAX = 8;
  localparam int PAT_MAX = 64;

  function automatic int state_w(input int pat_len);
    return (pat_len <= 2) ? 1 : $clog2(pat_len);
  endfunction

  function automatic logic [SYM_MAX-1:0] sym_at(
    input logic [PAT_MAX-1:0] pat,
    input int                 i,
    input int                 w
  );
    logic [PAT_MAX-1:0] sh;
    logic [SYM_MAX-1:0] mask;
    sh   = pat >> (i * w);
    mask = SYM_MAX'((1 << w) - 1);
    return sh[SYM_MAX-1:0] & mask;
  endfunction

endpackage

// File: rtl/mealy_seq_detector_if.sv
// Control, symbol stream and status bundle of the detector.
// master drives stimulus, slave is the detector side.
interface mealy_seq_detector_if
  import mealy_pkg::*;
#(
  parameter int SYM_W   = 2,
  parameter int PAT_LEN = 4,
  parameter int CNT_W   = 8
);

  localparam int SW = state_w(PAT_LEN);

  logic                     load;
  logic [SYM_W*PAT_LEN-1:0] pattern;
  logic                     overlap;
  logic                     in_valid;
  logic [SYM_W-1:0]         in_sym;
  logic                     match;
  logic [SW-1:0]            state;
  logic [CNT_W-1:0]         match_count;
  logic                     count_sat;

  modport master (
    output load, pattern, overlap,
    output in_valid, in_sym,
    input  match, state,
    input  match_count, count_sat
  );

  modport slave (
    input  load, pattern, overlap,
    input  in_valid, in_sym,
    output match, state,
    output match_count, count_sat
  );

endinterface

// File: rtl/mealy_seq_detector_sat_counter.sv
// Saturating event counter with synchronous reset and clear.
// The saturation flag is registered together with the count.
module mealy_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         sat
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         sat_q, sat_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !sat_q) begin
      cnt_d = cnt_q + W'(1);
    end
    sat_d = &cnt_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sat_q <= sat_d;
    end
  end

  assign cnt = cnt_q;
  assign sat = sat_q;

endmodule

// File: rtl/mealy_seq_detector.sv
// Programmable Mealy sequence detector with KMP-style fallback.
// Keeps the last PAT_LEN-1 symbols and picks the longest matching prefix.
module mealy_seq_detector
  import mealy_pkg::*;
#(
  parameter int SYM_W   = 2,
  parameter int PAT_LEN = 4,
  parameter int CNT_W   = 8
) (
  input logic                 clk,
  input logic                 rst,
  mealy_seq_detector_if.slave bus
);

  localparam int SW = state_w(PAT_LEN);
  localparam int PW = SYM_W * PAT_LEN;
  localparam int HW = SYM_W * (PAT_LEN - 1);

  logic [PW-1:0]        pat_q, pat_d;
  logic                 ovl_q, ovl_d;
  logic [SW-1:0]        state_q, state_d;
  logic [HW-1:0]        hist_q, hist_d;
  logic [PW-1:0]        win;
  logic [PAT_LEN-1:1]   hit;
  logic [SW-1:0]        best_k;
  logic [SYM_MAX-1:0]   last_sym;
  logic                 consume;
  logic                 match;

  // Newest symbol sits in the top slot of the window.
  assign win      = {bus.in_sym, hist_q};
  assign consume  = bus.in_valid & ~bus.load & ~rst;
  assign last_sym = sym_at(PAT_MAX'(pat_q), PAT_LEN - 1, SYM_W);
  assign match    = consume
                  & (state_q == SW'(PAT_LEN - 1))
                  & (SYM_MAX'(bus.in_sym) == last_sym);

  for (genvar k = 1; k < PAT_LEN; k++) begin : g_pref
    assign hit[k] = (pat_q[k*SYM_W-1:0] == win[PW-1 -: k*SYM_W]);
  end

  always_comb begin
    best_k = '0;
    for (int k = 1; k < PAT_LEN; k++) begin
      if (hit[k] && (k <= int'(state_q) + 1)) begin
        best_k = SW'(k);
      end
    end
  end

  always_comb begin
    pat_d   = pat_q;
    ovl_d   = ovl_q;
    state_d = state_q;
    hist_d  = hist_q;
    if (bus.load) begin
      pat_d   = bus.pattern;
      ovl_d   = bus.overlap;
      state_d = '0;
      hist_d  = '0;
    end else if (bus.in_valid) begin
      hist_d  = win[PW-1:SYM_W];
      state_d = (match && (ovl_q == MODE_NONOVL)) ? '0 : best_k;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q   <= '0;
      ovl_q   <= 1'b0;
      state_q <= '0;
      hist_q  <= '0;
    end else begin
      pat_q   <= pat_d;
      ovl_q   <= ovl_d;
      state_q <= state_d;
      hist_q  <= hist_d;
    end
  end

  mealy_sat_counter #(.W(CNT_W)) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (bus.load),
    .inc (match),
    .cnt (bus.match_count),
    .sat (bus.count_sat)
  );

  assign bus.match = match;
  assign bus.state = state_q;

endmodule

// File: tb/tb_mealy_seq_detector.sv
// Directed scoreboard bench for mealy_seq_detector.
// Two instances: 8-bit counter and 2-bit counter for saturation.
module tb_mealy_seq_detector;
  import mealy_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       load = 1'b0;
  logic       overlap = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] pattern = '0;
  logic [1:0] in_sym = '0;

  always #5 clk = ~clk;

  mealy_seq_detector_if #(.SYM_W(2), .PAT_LEN(4), .CNT_W(8)) ifa ();
  mealy_seq_detector_if #(.SYM_W(2), .PAT_LEN(4), .CNT_W(2)) ifb ();

  assign ifa.load = load;
  assign ifa.pattern = pattern;
  assign ifa.overlap = overlap;
  assign ifa.in_valid = in_valid;
  assign ifa.in_sym = in_sym;
  assign ifb.load = load;
  assign ifb.pattern = pattern;
  assign ifb.overlap = overlap;
  assign ifb.in_valid = in_valid;
  assign ifb.in_sym = in_sym;

  mealy_seq_detector #(.SYM_W(2), .PAT_LEN(4), .CNT_W(8)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  mealy_seq_detector #(.SYM_W(2), .PAT_LEN(4), .CNT_W(2)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  typedef struct {
    string name;
    bit    m;
    int    st;
    int    ca;
    int    sa;
    int    cb;
    int    sb;
  } exp_t;

  exp_t       sb_q[$];
  int         total = 0;
  int         passed = 0;
  string      tag = "";
  logic [7:0] cur_pat = '0;
  logic       cur_ovl = 1'b0;
  logic [1:0] s98 [4] = '{2'b00, 2'b10, 2'b01, 2'b10};

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic drv(input bit r, input bit l, input bit v,
                     input logic [1:0] s, input bit em,
                     input int st, input int ca, input int sa,
                     input int cb, input int sbx);
    exp_t e;
    @(posedge clk);
    #1;
    rst      = r;
    load     = l;
    pattern  = cur_pat;
    overlap  = cur_ovl;
    in_valid = v;
    in_sym   = s;
    e = '{tag, em, st, ca, sa, cb, sbx};
    sb_q.push_back(e);
  endtask

  task automatic sym(input logic [1:0] s, input bit em,
                     input int st, input int ca);
    drv(1'b0, 1'b0, 1'b1, s, em, st, ca, 0, -1, -1);
  endtask

  task automatic idle(input int st, input int ca);
    drv(1'b0, 1'b0, 1'b0, 2'b01, 1'b0, st, ca, 0, -1, -1);
  endtask

  task automatic ld(input logic [7:0] p, input logic o,
                    input bit v, input logic [1:0] s,
                    input int st, input int ca);
    cur_pat = p;
    cur_ovl = o;
    drv(1'b0, 1'b1, v, s, 1'b0, st, ca, 0, -1, -1);
  endtask

  // Monitor: one scoreboard entry per driven cycle, checked mid-cycle.
  initial begin
    forever begin
      exp_t e;
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk({e.name, " match_a"}, int'(ifa.match), int'(e.m));
        chk({e.name, " match_b"}, int'(ifb.match), int'(e.m));
        if (e.st >= 0) begin
          chk({e.name, " state_a"}, int'(ifa.state), e.st);
          chk({e.name, " state_b"}, int'(ifb.state), e.st);
        end
        if (e.ca >= 0)
          chk({e.name, " count_a"}, int'(ifa.match_count), e.ca);
        if (e.sa >= 0)
          chk({e.name, " sat_a"}, int'(ifa.count_sat), e.sa);
        if (e.cb >= 0)
          chk({e.name, " count_b"}, int'(ifb.match_count), e.cb);
        if (e.sb >= 0)
          chk({e.name, " sat_b"}, int'(ifb.count_sat), e.sb);
      end
    end
  end

  initial begin
    tag = "t1_reset";
    drv(1'b1, 1'b0, 1'b1, 2'b00, 1'b0, -1, -1, -1, -1, -1);
    drv(1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 0, 0, 0, 0, 0);
    drv(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 0, 0, 0, 0, 0);

    tag = "t2_basic";
    ld(8'h98, MODE_NONOVL, 1'b0, 2'b00, 0, 0);
    sym(2'b00, 1'b0, 0, 0);
    sym(2'b10, 1'b0, 1, 0);
    sym(2'b01, 1'b0, 2, 0);
    sym(2'b10, 1'b1, 3, 0);
    idle(0, 1);

    tag = "t3_ovl";
    ld(8'h88, MODE_OVL, 1'b0, 2'b00, 0, 1);
    sym(2'b00, 1'b0, 0, 0);
    sym(2'b10, 1'b0, 1, 0);
    sym(2'b00, 1'b0, 2, 0);
    sym(2'b10, 1'b1, 3, 0);
    sym(2'b00, 1'b0, 2, 1);
    sym(2'b10, 1'b1, 3, 1);
    idle(2, 2);

    tag = "t3_nonovl";
    ld(8'h88, MODE_NONOVL, 1'b0, 2'b00, 2, 2);
    sym(2'b00, 1'b0, 0, 0);
    sym(2'b10, 1'b0, 1, 0);
    sym(2'b00, 1'b0, 2, 0);
    sym(2'b10, 1'b1, 3, 0);
    sym(2'b00, 1'b0, 0, 1);
    sym(2'b10, 1'b0, 1, 1);
    idle(2, 1);

    tag = "t4_repeat";
    ld(8'h80, MODE_NONOVL, 1'b0, 2'b00, 2, 1);
    sym(2'b00, 1'b0, 0, 0);
    sym(2'b00, 1'b0, 1, 0);
    sym(2'b00, 1'b0, 2, 0);
    sym(2'b00, 1'b0, 3, 0);
    sym(2'b10, 1'b1, 3, 0);
    idle(0, 1);

    tag = "t5_gap";
    ld(8'h98, MODE_NONOVL, 1'b0, 2'b00, 0, 1);
    sym(2'b00, 1'b0, 0, 0);
    sym(2'b10, 1'b0, 1, 0);
    idle(2, 0);
    idle(2, 0);
    idle(2, 0);
    sym(2'b01, 1'b0, 2, 0);
    sym(2'b10, 1'b1, 3, 0);
    idle(0, 1);

    tag = "t5_load_mid";
    sym(2'b00, 1'b0, 0, 1);
    sym(2'b10, 1'b0, 1, 1);
    sym(2'b01, 1'b0, 2, 1);
    ld(8'h98, MODE_NONOVL, 1'b1, 2'b10, 3, 1);
    idle(0, 0);

    tag = "t6_sat";
    cur_pat = 8'h98;
    cur_ovl = MODE_NONOVL;
    drv(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 0, 0, 0, 0, 0);
    for (int r = 0; r < 5; r++) begin
      for (int j = 0; j < 4; j++) begin
        drv(1'b0, 1'b0, 1'b1, s98[j], (j == 3), j, r, 0,
            (r < 3) ? r : 3, (r >= 3) ? 1 : 0);
      end
    end
    drv(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 0, 5, 0, 3, 1);
    drv(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 0, 5, 0, 3, 1);
    drv(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 0, 0, 0, 0, 0);

    tag = "t7_rst_mid";
    sym(2'b00, 1'b0, 0, 0);
    sym(2'b10, 1'b0, 1, 0);
    drv(1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 2, 0, 0, 0, 0);
    sym(2'b00, 1'b0, 0, 0);
    idle(1, 0);

    repeat (3) @(negedge clk);
    tag = "drain";
    chk("drain queue_left", sb_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mealy_seq_detector.md
Name: mealy_seq_detector

Overview:
- Parametrised clocked Mealy sequence detector.
- Watches a stream of SYM_W-bit symbols qualified by in_valid and flags a programmable PAT_LEN-symbol pattern.
- The match output is Mealy: it is combinational from the current input symbol and the current state.
- Adds runtime-loadable pattern, overlap/non-overlap mode, a valid qualifier and a saturating match counter. Sits in the lab stimulus/monitor path.

Parameters:
SYM_W, 2, width of one input symbol
PAT_LEN, 4, pattern length in symbols; must be >= 2
CNT_W, 8, width of match counter

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
load  in  1  latch pattern and overlap, restart detection
pattern  in  SYM_W*PAT_LEN  pattern; symbol 0 (first expected) in LSBs
overlap  in  1  1 = overlapping matches allowed; sampled only on load
in_valid  in  1  in_sym is consumed this cycle
in_sym  in  SYM_W  input symbol
match  out  1  Mealy output: high in the cycle the final pattern symbol is consumed
state  out  $clog2(PAT_LEN)  length of the longest pattern prefix that is a suffix of consumed input (0..PAT_LEN-1)
match_count  out  CNT_W  number of matches since reset/load, saturating
count_sat  out  1  match_count == 2^CNT_W-1

Behaviour:
- Synchronous, active-high reset. After rst is sampled high:
  - pattern register = 0, overlap register = 0
  - state = 0, match_count = 0, count_sat = 0
- While rst = 1, match is forced to 0.
- Priority order: rst > load > in_valid.
- load = 1:
  - Latch pattern and overlap; state <- 0; match_count <- 0.
  - Any in_valid in the same cycle is dropped, and match = 0.
- in_valid = 0: all registers hold and match = 0.
- match = in_valid & ~load & ~rst & (state == PAT_LEN-1) & (in_sym == pat[PAT_LEN-1]). Zero latency: it is combinational in the consuming cycle.
- Next state on a consumed symbol (KMP semantics):
  - Let S be the consumed symbol history. New state = largest k < PAT_LEN such that the last k symbols of S equal pat[0..k-1].
  - Search is limited to k <= state+1, so only the last PAT_LEN-1 symbols are kept in a history shift register. Older history never matters.
  - On match with overlap = 1: state <- longest proper border of the pattern that is consistent with the history.
  - On match with overlap = 0: state <- 0.
- On a consumed symbol, history shifts in in_sym. load and rst clear history to 0.
- match_count:
  - Increments the cycle after match (registered).
  - Saturates at 2^CNT_W-1; no wrap.
  - count_sat is registered alongside the counter.
- Patterns with repeated symbols must fall back correctly. Example: 00,00,00,10 against stream 00 x4 holds state 3.
- Reset or load mid-pattern discards partial progress immediately. The next consumed symbol is evaluated from state 0.

Decomposition:
- Package mealy_pkg:
  - overlap mode constants MODE_NONOVL = 1'b0, MODE_OVL = 1'b1
  - function state_w(PAT_LEN) returning the state width
  - function sym_at(pattern, i) for symbol extraction
- One sub-module, mealy_sat_counter (CNT_W-wide, sync reset, clear, inc, sat flag), instantiated for match_count/count_sat.
- Prefix-compare logic stays in the top module as a generate loop over k.

Test Plan:
1. Reset with in_valid = 1 and in_sym = 00 held for 2 cycles -> match = 0, state = 0, match_count = 0, count_sat = 0.
2. Load pattern 8'h98 (00,10,01,10), overlap = 0, then stream 00,10,01,10 -> states after each symbol 1,2,3,0; match high only during the 4th symbol; match_count = 1 one cycle later.
3. Load 8'h88 (00,10,00,10), stream 00,10,00,10,00,10:
   - overlap = 1 -> match on symbols 4 and 6, state = 2 after symbol 4, match_count = 2.
   - overlap = 0 -> match only on symbol 4, match_count = 1.
4. Load 8'h80 (00,00,00,10), stream 00,00,00,00,10 -> states 1,2,3,3,0; match only on symbol 5.
5. Pattern 8'h98: stream 00,10, then 3 cycles in_valid = 0 with in_sym = 01, then 01,10 -> state holds at 2 with match = 0 during the gap; match on the final symbol. Load asserted with in_valid = 1 and in_sym = 10 at state = 3 -> match = 0, state = 0, count cleared.
6. CNT_W = 2, pattern 8'h98, 5 back-to-back non-overlapping matches -> match_count 1,2,3,3,3; count_sat rises after the 3rd match and stays high until rst or load.
